// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity modes and helpers.
// Imported by uart_rx_os, uart_baud_tick users and uart_tx.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP,
      BRK
   } uart_state_t;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_EVEN,
      PAR_ODD
   } par_mode_t;

   // Rounded clocks per sample tick
   function automatic int calc_div(
      input int clk_hz,
      input int baud,
      input int os
   );
      int den;
      den = baud * os;
      return (clk_hz + den / 2) / den;
   endfunction

   function automatic logic par_error(
      input par_mode_t mode,
      input logic      data_xor,
      input logic      par_bit
   );
      logic r;
      r = 1'b0;
      unique case (mode)
         PAR_EVEN: r = data_xor ^ par_bit;
         PAR_ODD:  r = ~(data_xor ^ par_bit);
         default:  r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divide-by-DIV sample tick generator.
// Held at zero while clr is high; tick fires on counter wrap.
module uart_baud_tick #(
   parameter int DIV = 27
) (
   input  logic clk,
   input  logic arst,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_wrap;

   assign w_wrap = (r_cnt == CW'(DIV - 1));
   assign tick   = w_wrap & ~clr;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_cnt <= '0;
      end else if (clr || w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority vote,
// false-start rejection, break detect and a one-word output register.
module uart_rx_os #(
   parameter int    CLK_FREQ   = 50_000_000,
   parameter int    BAUD_RATE  = 115200,
   parameter string PARITY     = "NONE",
   parameter int    DATA_WIDTH = 8,
   parameter int    OVERSAMPLE = 16
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  RXD,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  break_det,
   output logic                  overrun
);

   import uart_pkg::*;

   localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int M   = OVERSAMPLE / 2;
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_WIDTH);
   localparam par_mode_t PMODE =
      (PARITY == "EVEN") ? PAR_EVEN :
      (PARITY == "ODD")  ? PAR_ODD  : PAR_NONE;

   if (DIV < 1) begin : g_div_chk
      $error("uart_rx_os: DIV must be >= 1");
   end
   if (OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0) begin : g_os_chk
      $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
   end
   if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_dw_chk
      $error("uart_rx_os: DATA_WIDTH must be 5..9");
   end
   if (PARITY != "NONE" && PARITY != "EVEN" && PARITY != "ODD") begin : g_par_chk
      $error("uart_rx_os: PARITY must be NONE, EVEN or ODD");
   end

   uart_state_t r_state, w_next;

   logic [1:0]            r_sync;
   logic                  r_rxs_d;
   logic                  w_rxs;
   logic                  w_clr;
   logic                  w_tick;
   logic [SW-1:0]         r_s;
   logic [BW-1:0]         r_bits;
   logic                  r_v0, r_v1;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_par;
   logic                  w_bit;
   logic                  w_vote;
   logic                  w_bit_end;
   logic                  w_last;
   logic                  w_done;
   logic                  w_brk;
   logic                  w_pe;

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_pe;
   logic                  r_fe;
   logic                  r_brk_det;
   logic                  r_ovr;

   assign w_rxs = r_sync[1];
   assign w_clr = (r_state == IDLE);

   uart_baud_tick #(
      .DIV(DIV)
   ) u_tick (
      .clk (clk),
      .arst(arst),
      .clr (w_clr),
      .tick(w_tick)
   );

   // Vote is resolved on the third sample tick (s = M+1)
   assign w_bit     = (r_v0 & r_v1) | (r_v0 & w_rxs) | (r_v1 & w_rxs);
   assign w_vote    = w_tick && (r_s == SW'(M + 1));
   assign w_bit_end = w_tick && (r_s == SW'(OVERSAMPLE - 1));
   assign w_last    = (r_bits == BW'(DATA_WIDTH - 1));
   assign w_done    = (r_state == STOP) && w_vote;
   assign w_brk     = w_done && !w_bit && (r_shift == '0) &&
                      ((PMODE == PAR_NONE) || !r_par);
   assign w_pe      = par_error(PMODE, ^r_shift, r_par);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_sync  <= 2'b11;
         r_rxs_d <= 1'b1;
      end else begin
         r_sync  <= {r_sync[0], RXD};
         r_rxs_d <= r_sync[1];
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (r_rxs_d && !w_rxs) w_next = START;
         end
         START: begin
            if (w_vote && w_bit) w_next = IDLE;
            else if (w_bit_end)  w_next = DATA;
         end
         DATA: begin
            if (w_bit_end && w_last)
               w_next = (PMODE == PAR_NONE) ? STOP : PAR;
         end
         PAR: begin
            if (w_bit_end) w_next = STOP;
         end
         STOP: begin
            if (w_vote) w_next = w_brk ? BRK : IDLE;
         end
         BRK: begin
            if (w_rxs) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_s     <= '0;
         r_bits  <= '0;
         r_v0    <= 1'b0;
         r_v1    <= 1'b0;
         r_shift <= '0;
         r_par   <= 1'b0;
      end else begin
         if (r_state == IDLE) begin
            r_s    <= '0;
            r_bits <= '0;
         end else if (w_tick) begin
            r_s <= (r_s == SW'(OVERSAMPLE - 1)) ? '0 : r_s + SW'(1);
            if (r_s == SW'(M - 1)) r_v0 <= w_rxs;
            if (r_s == SW'(M))     r_v1 <= w_rxs;
         end
         if (r_state == DATA && w_vote)
            r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
         if (r_state == DATA && w_bit_end)
            r_bits <= r_bits + BW'(1);
         if (r_state == PAR && w_vote)
            r_par <= w_bit;
      end
   end

   // A new word may load in the same cycle the held one is taken
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_pe      <= 1'b0;
         r_fe      <= 1'b0;
         r_brk_det <= 1'b0;
         r_ovr     <= 1'b0;
      end else begin
         r_brk_det <= w_brk;
         r_ovr     <= 1'b0;
         if (w_done) begin
            if (!r_valid || rx_ready) begin
               r_data  <= r_shift;
               r_pe    <= w_pe;
               r_fe    <= ~w_bit;
               r_valid <= 1'b1;
            end else begin
               r_ovr <= 1'b1;
            end
         end else if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_data    = r_data;
   assign rx_valid   = r_valid;
   assign parity_err = r_pe;
   assign frame_err  = r_fe;
   assign break_det  = r_brk_det;
   assign overrun    = r_ovr;

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
UART receive end with 16x oversampling. Recovers frames driven by the team's UART transmitter over a single RXD line. Adds majority-vote bit sampling, false-start rejection, break detection and a one-entry output register with a ready/valid handshake, so the block can feed byte-wide consumers that stall.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bits/s
PARITY, "NONE", one of "NONE", "EVEN", "ODD"; selects whether a parity bit follows the data
DATA_WIDTH, 8, data bits per frame, LSB first, legal range 5..9
OVERSAMPLE, 16, sample ticks per bit; must be even, >=8
DIV (localparam), round(CLK_FREQ/(BAUD_RATE*OVERSAMPLE)), clocks per sample tick; elaboration error if <1

Ports:
clk  input  1  system clock, all logic rising-edge
arst  input  1  asynchronous, active-high reset
RXD  input  1  serial line, idle high, asynchronous to clk
rx_data  output  DATA_WIDTH  received word, valid while rx_valid=1
rx_valid  output  1  word held in output register
rx_ready  input  1  consumer accepts word when rx_valid&rx_ready
parity_err  output  1  parity mismatch on held word, qualified by rx_valid
frame_err  output  1  stop bit sampled low on held word, qualified by rx_valid
break_det  output  1  one-clock pulse when a break condition is detected
overrun  output  1  one-clock pulse when a completed frame is dropped

Behaviour:
- Reset: all outputs 0 (rx_data all zero); FSM IDLE; tick counter 0; synchroniser flops preset to 1. Reset mid-frame aborts the frame with no output.
- RXD passes a 2-flop synchroniser (value 1 on reset); all logic uses the synchronised line rxs.
- Tick generator: counter 0..DIV-1; tick=1 on wrap. Free-running only outside IDLE; cleared on IDLE->START.
- Each bit is OVERSAMPLE ticks, indexed s=0..OVERSAMPLE-1. The bit value is the majority of rxs at ticks s=M-1, M, M+1, where M=OVERSAMPLE/2.
- FSM states: IDLE, START, DATA, PAR, STOP, BRK.
  - IDLE: a falling edge on rxs (1 then 0) -> START.
  - START: at the voted sample, 1 -> IDLE (false start, no outputs); 0 -> DATA at the end of the bit period.
  - DATA: shifts DATA_WIDTH bits LSB-first into the shift register. After the last bit, go to PAR if PARITY!="NONE", else STOP.
  - PAR: stores the voted bit. EVEN: the XOR of the data bits and the parity bit must be 0. ODD: it must be 1.
  - STOP: the frame completes at the voted sample (s=M+1), not at the end of the bit. Stop=1 -> IDLE. Stop=0 with a break (all data bits 0, parity bit 0 or absent) -> BRK. Any other stop=0 -> IDLE.
  - BRK: waits for rxs=1, then goes to IDLE. No new start bit is recognised in BRK.
- Frame completion (cycle T = cycle of the voted stop sample):
  - The output register is empty, or rx_ready=1 in cycle T: in cycle T+1 rx_data/parity_err/frame_err load and rx_valid=1.
  - Otherwise (held word, rx_ready=0): the held word and its flags are unchanged, and overrun pulses in T+1.
- Break: the break frame is loaded like any completed frame, with frame_err=1 and rx_data=0. break_det pulses in T+1. If the frame is dropped instead, both overrun and break_det pulse.
- Handshake: rx_valid&rx_ready clears rx_valid next cycle unless a new word loads in the same cycle; in that case rx_valid stays 1 with the new word. rx_data is stable while rx_valid=1 and no transfer occurs.
- PARITY="NONE": parity_err always 0.
- A falling edge during STOP after the voted sample is recognised from IDLE in the next cycle. This allows back-to-back frames with one stop bit.

Decomposition:
- Shared package uart_pkg: the FSM state enum, the parity-mode encodings, and functions for DIV rounding and parity calculation. The same package is reused by uart_tx.
- One sub-module, uart_baud_tick (parameters DIV; ports clk, arst, clr, tick). It replaces the ad-hoc counter so uart_tx can reuse it.

Test Plan:
- Defaults (DIV=27, 432 clk/bit); send 0xA5, rx_ready=1 -> rx_valid pulses 1 clk with rx_data=0xA5, parity_err=0, frame_err=0, 1 clk after the mid-stop sample.
- PARITY="EVEN"; send 0x03 with parity bit 1 (wrong) -> rx_data=0x03, parity_err=1. Send 0x03 with parity bit 0 -> parity_err=0.
- Glitch: RXD low for 100 clk (<216), then high -> no rx_valid, FSM back in IDLE; a following 0x5A is received correctly.
- rx_ready=0; send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun pulses once; after rx_ready=1, rx_valid falls.
- RXD held low for 3 frame times -> one word 0x00 with frame_err=1, break_det pulses once, no further words until RXD returns high; the next 0x7E is received.
- Assert arst mid-data-bit 4 of 0xFF -> all outputs 0 immediately; after release the remainder of that frame yields no rx_valid, and the next full 0x81 frame is received.
